dog_thresh_bbox: RTL and testbench

- Post-processing stage directly downstream of the DoG stage.
- After DoG completes, streams the full DoG result image (IMG_W x IMG_H bytes, raster order) out of the result RAM read port.
- Binarises each pixel against a programmable threshold and writes the binary map to a separate output RAM.
- Also reports the above-threshold pixel count and the bounding box of those pixels to control logic.

---
 rtl/dog_thresh_bbox.sv | 137 +++++++++++++
 tb/tb_dog_thresh_bbox.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dog_thresh_bbox.sv
// Thresholds the DoG result image into a binary map and tracks the
// above-threshold pixel count and bounding box for control logic.
module dog_thresh_bbox #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int AW    = 16,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DW-1:0]            thresh,
    output logic                     ram_rd_valid_o,
    output logic [AW-1:0]            ram_rd_addr_o,
    input  logic                     ram_valid_in,
    input  logic [DW-1:0]            ram_data_in,
    output logic                     bin_wr_valid_o,
    output logic [AW-1:0]            bin_wr_addr_o,
    output logic [DW-1:0]            bin_wr_data_o,
    output logic [AW:0]              cnt_o,
    output logic [$clog2(IMG_W)-1:0] xmin_o,
    output logic [$clog2(IMG_W)-1:0] xmax_o,
    output logic [$clog2(IMG_H)-1:0] ymin_o,
    output logic [$clog2(IMG_H)-1:0] ymax_o,
    output logic                     bbox_valid_o,
    output logic                     busy,
    output logic                     done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [AW:0]   NPIX      = (AW+1)'(IMG_W * IMG_H);
    localparam logic [AW:0]   NPIX_M1   = (AW+1)'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   thresh_q;
    logic [AW-1:0]   rd_addr;
    logic [AW:0]     rc;
    logic [AW:0]     cnt;
    logic [XW-1:0]   xmin, xmax;
    logic [YW-1:0]   ymin, ymax;
    logic            wr_vld_p1;
    logic [AW-1:0]   wr_addr_p1;
    logic [DW-1:0]   wr_data_p1;
    logic            done_q;

    logic            ret_ok;
    logic            hit;
    logic [XW-1:0]   px;
    logic [YW-1:0]   py;

    // Returns count only while a pass is active and before all N have arrived.
    assign ret_ok = (state == READ || state == DRAIN) && ram_valid_in && (rc != NPIX);
    assign hit    = ram_data_in > thresh_q;
    assign px     = rc[XW-1:0];
    assign py     = rc[XW+YW-1:XW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = READ;
            READ:  if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
            // Leave as the last return lands so done is two cycles after it.
            DRAIN: if (rc == NPIX || (ret_ok && rc == NPIX_M1)) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_rd_valid_o = (state == READ);
        busy           = (state != IDLE);
    end

    // Return stage: one registered write and statistics update per valid return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q   <= '0;
            rd_addr    <= '0;
            rc         <= '0;
            cnt        <= '0;
            xmin       <= '0;
            xmax       <= '0;
            ymin       <= '0;
            ymax       <= '0;
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q    <= (state == FIN);
            wr_vld_p1 <= ret_ok;
            if (state == IDLE && start) begin
                thresh_q <= thresh;
                rd_addr  <= '0;
                rc       <= '0;
                cnt      <= '0;
                xmin     <= '1;
                ymin     <= '1;
                xmax     <= '0;
                ymax     <= '0;
            end
            if (state == READ) rd_addr <= rd_addr + 1'b1;
            if (ret_ok) begin
                rc         <= rc + 1'b1;
                wr_addr_p1 <= rc[AW-1:0];
                wr_data_p1 <= hit ? '1 : '0;
                if (hit) begin
                    cnt <= cnt + 1'b1;
                    if (px < xmin) xmin <= px;
                    if (px > xmax) xmax <= px;
                    if (py < ymin) ymin <= py;
                    if (py > ymax) ymax <= py;
                end
            end
        end
    end

    assign ram_rd_addr_o  = rd_addr;
    assign bin_wr_valid_o = wr_vld_p1;
    assign bin_wr_addr_o  = wr_addr_p1;
    assign bin_wr_data_o  = wr_data_p1;
    assign cnt_o          = cnt;
    assign xmin_o         = xmin;
    assign xmax_o         = xmax;
    assign ymin_o         = ymin;
    assign ymax_o         = ymax;
    assign bbox_valid_o   = (cnt != '0);
    assign done           = done_q;
endmodule

// File: tb/tb_dog_thresh_bbox.sv
// Scoreboard bench for dog_thresh_bbox on a reduced 64x64 image with a
// variable-latency RAM model feeding the return path.
module tb_dog_thresh_bbox;
    localparam int IMG_W = 64;
    localparam int IMG_H = 64;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int N     = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] thresh;
    logic          ram_rd_valid_o;
    logic [AW-1:0] ram_rd_addr_o;
    logic          ram_valid_in;
    logic [DW-1:0] ram_data_in;
    logic          bin_wr_valid_o;
    logic [AW-1:0] bin_wr_addr_o;
    logic [DW-1:0] bin_wr_data_o;
    logic [AW:0]   cnt_o;
    logic [5:0]    xmin_o, xmax_o, ymin_o, ymax_o;
    logic          bbox_valid_o, busy, done;

    dog_thresh_bbox #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .thresh(thresh),
        .ram_rd_valid_o(ram_rd_valid_o), .ram_rd_addr_o(ram_rd_addr_o),
        .ram_valid_in(ram_valid_in), .ram_data_in(ram_data_in),
        .bin_wr_valid_o(bin_wr_valid_o), .bin_wr_addr_o(bin_wr_addr_o),
        .bin_wr_data_o(bin_wr_data_o), .cnt_o(cnt_o),
        .xmin_o(xmin_o), .xmax_o(xmax_o), .ymin_o(ymin_o), .ymax_o(ymax_o),
        .bbox_valid_o(bbox_valid_o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM model: fixed read latency lat (1..3 cycles)
    logic [DW-1:0] img [N];
    int            lat = 1;
    logic [2:0]    pv = '0;
    logic [AW-1:0] pa [3];
    initial for (int i = 0; i < 3; i++) pa[i] = '0;
    always @(posedge clk) begin
        pv    <= {pv[1:0], ram_rd_valid_o};
        pa[0] <= ram_rd_addr_o;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
    end
    assign ram_valid_in = pv[lat-1];
    assign ram_data_in  = img[pa[lat-1]];

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    typedef struct packed {
        logic [AW:0] cnt;
        logic [5:0]  xmin, xmax, ymin, ymax;
        logic        bv;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, last_v = -100, rd_cnt = 0, done_cnt = 0;

    always @(posedge clk) cyc++;

    // Monitor: pops expected writes/results whenever the DUT presents them
    always @(negedge clk) begin
        wr_t  e;
        res_t r, got;
        if (ram_valid_in) last_v = cyc;
        if (ram_rd_valid_o) rd_cnt++;
        if (bin_wr_valid_o) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%0h data=%0h, required no write", bin_wr_addr_o, bin_wr_data_o);
            end else begin
                e = wq.pop_front();
                if (bin_wr_addr_o !== e.a || bin_wr_data_o !== e.d) begin
                    errors++;
                    $display("FAIL wr: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             bin_wr_addr_o, bin_wr_data_o, e.a, e.d);
                end
            end
        end
        if (done) begin
            done_cnt++;
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done pulse with no pass expected");
            end else begin
                r   = rq.pop_front();
                got = '{cnt: cnt_o, xmin: xmin_o, xmax: xmax_o, ymin: ymin_o, ymax: ymax_o, bv: bbox_valid_o};
                if (got !== r) begin
                    errors++;
                    $display("FAIL result: got cnt=%0d x=%0d..%0d y=%0d..%0d bv=%0b, required cnt=%0d x=%0d..%0d y=%0d..%0d bv=%0b",
                             got.cnt, got.xmin, got.xmax, got.ymin, got.ymax, got.bv,
                             r.cnt, r.xmin, r.xmax, r.ymin, r.ymax, r.bv);
                end
                checks++;
                if (cyc - last_v != 2) begin
                    errors++;
                    $display("FAIL done_latency: got %0d cycles after last valid, required 2", cyc - last_v);
                end
                checks++;
                if (wq.size() != 0) begin
                    errors++;
                    $display("FAIL wr_count: got %0d writes missing at done, required 0", wq.size());
                end
            end
        end
    end

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++) img[i] = DW'(i);
    endtask

    task automatic expect_pass(input logic [DW-1:0] th);
        res_t r;
        int   x, y;
        r = '{cnt: '0, xmin: 6'h3F, xmax: 6'h00, ymin: 6'h3F, ymax: 6'h00, bv: 1'b0};
        for (int i = 0; i < N; i++) begin
            if (img[i] > th) begin
                wq.push_back('{a: AW'(i), d: 8'hFF});
                x = i % IMG_W;
                y = i / IMG_W;
                r.cnt++;
                if (x < int'(r.xmin)) r.xmin = 6'(x);
                if (x > int'(r.xmax)) r.xmax = 6'(x);
                if (y < int'(r.ymin)) r.ymin = 6'(y);
                if (y > int'(r.ymax)) r.ymax = 6'(y);
            end else begin
                wq.push_back('{a: AW'(i), d: 8'h00});
            end
        end
        r.bv = (r.cnt != 0);
        rq.push_back(r);
    endtask

    task automatic pulse_start(input logic [DW-1:0] th);
        @(negedge clk);
        start  = 1'b1;
        thresh = th;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int k;
        k = 0;
        while (done_cnt == d0 && k < N + 200) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_timeout: got no done in %0d cycles, required one", name, k);
        end
    endtask

    task automatic run(input logic [DW-1:0] th, input string name);
        int d0;
        d0 = done_cnt;
        expect_pass(th);
        pulse_start(th);
        wait_done(d0, name);
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_done: got %0d dones busy=%0b, required 1 done busy=0", name, done_cnt - d0, busy);
        end
    endtask

    task automatic check_zero(input string name);
        logic [73:0] v;
        v = {ram_rd_valid_o, ram_rd_addr_o, bin_wr_valid_o, bin_wr_addr_o, bin_wr_data_o,
             cnt_o, xmin_o, xmax_o, ymin_o, ymax_o, bbox_valid_o, busy, done};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: got outputs=%h, required all zero", name, v);
        end
    endtask

    initial begin
        int d0, r0, k;
        rst = 1'b1; start = 1'b0; thresh = '0;
        fill(8'h00);
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fill(8'h00);
        run(8'h00, "all_zero");

        img[12'h234] = 8'd200;
        run(8'd100, "single_pixel");

        fill(8'hFF);
        run(8'd254, "all_ff_254");
        run(8'd255, "all_ff_255");

        fill(8'h00);
        img[20*IMG_W + 10] = 8'h80;
        img[3*IMG_W + 50]  = 8'h80;
        lat = 1;
        run(8'h7F, "two_px_lat1");
        lat = 3;
        run(8'h7F, "two_px_lat3");

        // Abort mid-pass after 1000 reads
        lat = 1;
        fill_ramp();
        d0 = done_cnt;
        r0 = rd_cnt;
        expect_pass(8'h80);
        pulse_start(8'h80);
        k = 0;
        while (rd_cnt - r0 < 1000 && k < N) begin
            @(negedge clk);
            k++;
        end
        #2 rst = 1'b1;
        wq.delete();
        rq.delete();
        #1 check_zero("abort_async");
        @(negedge clk);
        check_zero("abort_next_cycle");
        rst = 1'b0;
        r0 = rd_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (rd_cnt != r0 || done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got reads=%0d dones=%0d busy=%0b, required 0 0 0",
                     rd_cnt - r0, done_cnt - d0, busy);
        end
        run(8'h80, "after_abort");

        // start held high with a new threshold mid-pass
        d0 = done_cnt;
        expect_pass(8'h80);
        pulse_start(8'h80);
        repeat (50) @(negedge clk);
        thresh = 8'h10;
        start  = 1'b1;
        repeat (10) @(negedge clk);
        start  = 1'b0;
        wait_done(d0, "start_held");
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_held_single: got %0d dones busy=%0b, required 1 done busy=0", done_cnt - d0, busy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
